// File: rtl/luhn_generator.sv
// Luhn check-digit generator: collects CARD_LEN-1 BCD payload digits, computes
// the mod-10 check digit, then streams the full card out over a ready/valid link.
module luhn_generator #(
  parameter int CARD_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic [3:0] serial_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [3:0] check_digit,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, EMIT} state_t;

  localparam logic [3:0] LAST_PAY  = 4'(CARD_LEN - 2);
  localparam logic [3:0] LAST_IDX  = 4'(CARD_LEN - 1);
  // Payload digit i is doubled when (CARD_LEN-2-i) is even, i.e. when i and CARD_LEN share parity.
  localparam logic       DBL_PHASE = 1'(CARD_LEN % 2);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] acc;
  logic [3:0] buffer [16];

  logic       digit_xfer;
  logic       out_xfer;
  logic       bad_digit;
  logic       final_xfer;
  logic [4:0] dbl;
  logic [3:0] weighted;
  logic [4:0] acc_sum;
  logic [3:0] acc_nxt;
  logic [3:0] check_val;

  assign digit_xfer = (state == COLLECT) && digit_valid;
  assign out_xfer   = (state == EMIT) && out_ready;
  assign bad_digit  = digit_in > 4'd9;
  assign final_xfer = out_xfer && (cnt == LAST_IDX);

  // Weighted digit and running mod-10 sum; the accumulator never leaves 0..9.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    weighted = digit_in;
    dbl      = {digit_in, 1'b0};
    if (cnt[0] == DBL_PHASE) begin
      weighted = (dbl > 5'd9) ? 4'(dbl - 5'd9) : dbl[3:0];
    end
    acc_sum = {1'b0, acc} + {1'b0, weighted};
    acc_nxt = (acc_sum >= 5'd10) ? 4'(acc_sum - 5'd10) : acc_sum[3:0];
  end

  assign check_val = (acc == 4'd0) ? 4'd0 : 4'(4'd10 - acc);

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (digit_xfer) begin
          if (bad_digit)            state_nxt = IDLE;
          else if (cnt == LAST_PAY) state_nxt = CALC;
        end
      end
      CALC:    state_nxt = EMIT;
      EMIT:    if (final_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter doubles as payload index in COLLECT and output index in EMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      acc         <= '0;
      check_digit <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= final_xfer;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            acc <= '0;
            err <= 1'b0;
          end
        end
        COLLECT: begin
          if (digit_xfer) begin
            if (bad_digit) begin
              err <= 1'b1;
            end else begin
              acc <= acc_nxt;
              cnt <= (cnt == LAST_PAY) ? 4'd0 : cnt + 4'd1;
            end
          end
        end
        CALC: check_digit <= check_val;
        EMIT: begin
          if (out_xfer) cnt <= final_xfer ? 4'd0 : cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the digit buffer is deliberately not reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (digit_xfer && !bad_digit) buffer[cnt] <= digit_in;
    if (state == CALC)            buffer[LAST_IDX] <= check_val;
  end

  assign digit_ready = (state == COLLECT);
  assign out_valid   = (state == EMIT);
  assign serial_out  = out_valid ? buffer[cnt] : 4'd0;
  assign out_last    = out_valid && (cnt == LAST_IDX);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_luhn_generator.sv
// Bench for luhn_generator: two instances (16- and 11-digit cards) checked
// against a Luhn model that searches for the digit making the full card valid.
module tb_luhn_generator;

  typedef int dq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start       [2];
  logic [3:0] digit_in    [2];
  logic       digit_valid [2];
  logic       digit_ready [2];
  logic [3:0] serial_out  [2];
  logic       out_valid   [2];
  logic       out_ready   [2];
  logic       out_last    [2];
  logic [3:0] check_digit [2];
  logic       busy        [2];
  logic       done        [2];
  logic       err         [2];

  int tests = 0;
  int fails = 0;
  int last_cd [2];

  luhn_generator #(.CARD_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .start(start[0]), .digit_in(digit_in[0]),
    .digit_valid(digit_valid[0]), .digit_ready(digit_ready[0]),
    .serial_out(serial_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .check_digit(check_digit[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  luhn_generator #(.CARD_LEN(11)) dut11 (
    .clk(clk), .rst(rst), .start(start[1]), .digit_in(digit_in[1]),
    .digit_valid(digit_valid[1]), .digit_ready(digit_ready[1]),
    .serial_out(serial_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .check_digit(check_digit[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  function automatic int card_len(input int s);
    return (s == 0) ? 16 : 11;
  endfunction

  // Reference: the check digit is the unique c in 0..9 that makes the whole card
  // pass the Luhn test (every second digit from the right doubled, sum mod 10 == 0).
  function automatic int luhn_ref(input dq_t pay);
    dq_t full;
    int  sum;
    int  d;
    for (int c = 0; c < 10; c++) begin
      full = pay;
      full.push_back(c);
      sum = 0;
      for (int p = 0; p < full.size(); p++) begin
        d = full[full.size() - 1 - p];
        if (p % 2 == 1) begin
          d = d * 2;
          if (d > 9) d = d - 9;
        end
        sum += d;
      end
      if (sum % 10 == 0) return c;
    end
    return -1;
  endfunction

  function automatic dq_t str_digits(input string str);
    dq_t q;
    for (int i = 0; i < str.len(); i++) q.push_back(int'(str[i]) - 48);
    return q;
  endfunction

  task automatic expect_zero(input int s, input string name);
    logic [13:0] obs;
    obs = {digit_ready[s], serial_out[s], out_valid[s], out_last[s], check_digit[s],
           busy[s], done[s], err[s]};
    tests++;
    if (obs !== 14'd0) begin
      fails++;
      $display("FAIL %s dut%0d: outputs=0x%h expected 0x0000", name, s, obs);
    end
  endtask

  // One complete card on instance s. prestarted: start was already raised at the
  // previous negedge. abort_k >= 0: assert reset while serial index == abort_k.
  task automatic run_card(input int s, input dq_t pay, input bit gaps, input bit stall,
                          input bit noise, input bit b2b_next, input bit prestarted,
                          input int abort_k);
    int         len;
    int         exp_cd;
    int         idx;
    int         cyc;
    int         last_xfer;
    int         first_val;
    int         last_out;
    int         bad_at;
    bit         finished;
    bit         prev_stall;
    bit         rdy;
    logic [3:0] prev_val;
    logic [3:0] got[$];
    len        = card_len(s);
    exp_cd     = luhn_ref(pay);
    idx        = 0;
    cyc        = 0;
    last_xfer  = -1;
    first_val  = -1;
    last_out   = -1;
    finished   = 1'b0;
    prev_stall = 1'b0;
    prev_val   = 4'd0;
    rdy        = 1'b1;
    if (!prestarted) begin
      @(negedge clk);
      start[s] = 1'b1;
    end
    @(negedge clk);
    start[s] = 1'b0;
    tests++;
    if (busy[s] !== 1'b1 || err[s] !== 1'b0 || done[s] !== 1'b0 || digit_ready[s] !== 1'b1) begin
      fails++;
      $display("FAIL start_accept dut%0d: busy=%b err=%b done=%b ready=%b expected 1 0 0 1",
               s, busy[s], err[s], done[s], digit_ready[s]);
    end
    while (!finished && cyc < 400) begin
      if (idx < len - 1) begin
        digit_valid[s] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        digit_in[s]    = 4'(pay[idx]);
        start[s]       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (digit_valid[s] && digit_ready[s]) begin
          idx++;
          if (idx == len - 1) last_xfer = cyc;
        end
      end else begin
        start[s]       = 1'b0;
        digit_valid[s] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        digit_in[s]    = 4'($urandom_range(0, 15));
      end
      rdy          = stall ? ~rdy : 1'b1;
      out_ready[s] = rdy;
      if (out_valid[s]) begin
        if (first_val < 0) begin
          first_val = cyc;
          tests++;
          if (first_val - last_xfer != 2 || last_xfer < 0) begin
            fails++;
            $display("FAIL latency dut%0d: first out_valid %0d cycles after last payload, expected 2",
                     s, first_val - last_xfer);
          end
          tests++;
          if (check_digit[s] !== 4'(exp_cd)) begin
            fails++;
            $display("FAIL check_digit dut%0d: got %0d expected %0d", s, check_digit[s], exp_cd);
          end
        end
        if (prev_stall) begin
          tests++;
          if (serial_out[s] !== prev_val) begin
            fails++;
            $display("FAIL stall_hold dut%0d: serial_out %0d changed from %0d during stall",
                     s, serial_out[s], prev_val);
          end
        end
        tests++;
        if (out_last[s] !== (got.size() == len - 1)) begin
          fails++;
          $display("FAIL out_last dut%0d: got %b at index %0d of %0d", s, out_last[s], got.size(), len);
        end
        if (abort_k >= 0 && got.size() == abort_k) begin
          rst = 1'b0;
          #1;
          expect_zero(0, "abort_reset");
          expect_zero(1, "abort_reset");
          for (int j = 0; j < 2; j++) begin
            start[j] = 1'b0; digit_valid[j] = 1'b0; out_ready[j] = 1'b1;
          end
          last_cd[0] = 0;
          last_cd[1] = 0;
          @(negedge clk);
          rst = 1'b1;
          repeat (3) @(negedge clk);
          expect_zero(s, "after_abort");
          return;
        end
        if (rdy) begin
          got.push_back(serial_out[s]);
          if (got.size() == len) begin
            finished = 1'b1;
            last_out = cyc;
          end
        end
        prev_stall = !rdy;
        prev_val   = serial_out[s];
      end else if (first_val >= 0) begin
        prev_stall = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL timeout dut%0d: %0d of %0d digits after %0d cycles", s, got.size(), len, cyc);
      return;
    end
    bad_at = -1;
    for (int i = len - 1; i >= 0; i--) begin
      if (got[i] !== 4'((i == len - 1) ? exp_cd : pay[i])) bad_at = i;
    end
    if (bad_at >= 0) begin
      fails++;
      $display("FAIL stream dut%0d: digit %0d got %0d expected %0d", s, bad_at, got[bad_at],
               (bad_at == len - 1) ? exp_cd : pay[bad_at]);
    end
    if (!stall) begin
      tests++;
      if (last_out - first_val != len - 1) begin
        fails++;
        $display("FAIL throughput dut%0d: %0d cycles for emission expected %0d",
                 s, last_out - first_val + 1, len);
      end
    end
    tests++;
    if (done[s] !== 1'b1 || busy[s] !== 1'b0 || out_valid[s] !== 1'b0 ||
        digit_ready[s] !== 1'b0 || check_digit[s] !== 4'(exp_cd)) begin
      fails++;
      $display("FAIL done_cycle dut%0d: done=%b busy=%b valid=%b ready=%b cd=%0d expected 1 0 0 0 %0d",
               s, done[s], busy[s], out_valid[s], digit_ready[s], check_digit[s], exp_cd);
    end
    digit_valid[s] = 1'b0;
    start[s]       = b2b_next;
    last_cd[s]     = exp_cd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      start[j] = 1'b1; digit_valid[j] = 1'b1; digit_in[j] = 4'd5; out_ready[j] = 1'b1;
      last_cd[j] = 0;
    end
    #1;
    expect_zero(0, "reset_immediate");
    expect_zero(1, "reset_immediate");
    repeat (3) @(negedge clk);
    expect_zero(0, "reset_held");
    expect_zero(1, "reset_held");
    for (int j = 0; j < 2; j++) begin
      start[j] = 1'b0; digit_valid[j] = 1'b0;
    end
    // Release reset with start already high so the first rising edge must honour it.
    rst      = 1'b1;
    start[0] = 1'b1;
  endtask

  task automatic test_known_16();
    run_card(0, str_digits("453914880343646"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    tests++;
    if (check_digit[0] !== 4'd7) begin
      fails++;
      $display("FAIL known_16: check_digit %0d expected 7", check_digit[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_card(0, str_digits("999999999999999"), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    tests++;
    if (check_digit[0] !== 4'd5) begin
      fails++;
      $display("FAIL nines: check_digit %0d expected 5", check_digit[0]);
    end
    run_card(0, str_digits("000000000000000"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    tests++;
    if (check_digit[0] !== 4'd0) begin
      fails++;
      $display("FAIL zeros: check_digit %0d expected 0", check_digit[0]);
    end
  endtask

  task automatic test_len11();
    run_card(1, str_digits("7992739871"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    tests++;
    if (check_digit[1] !== 4'd3) begin
      fails++;
      $display("FAIL len11: check_digit %0d expected 3", check_digit[1]);
    end
  endtask

  task automatic test_stall();
    run_card(0, str_digits("453914880343646"), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    tests++;
    if (check_digit[0] !== 4'd7) begin
      fails++;
      $display("FAIL stall: check_digit %0d expected 7", check_digit[0]);
    end
  endtask

  task automatic test_bad_digit();
    dq_t pay;
    int  idx;
    int  guard;
    bit  leak;
    pay    = str_digits("453914880343646");
    pay[4] = 10;
    idx    = 0;
    guard  = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    while (idx < 5 && guard < 50) begin
      digit_valid[0] = 1'b1;
      digit_in[0]    = 4'(pay[idx]);
      if (digit_ready[0]) idx++;
      @(negedge clk);
      guard++;
    end
    digit_valid[0] = 1'b0;
    tests++;
    if (idx < 5 || err[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0 ||
        digit_ready[0] !== 1'b0 || check_digit[0] !== 4'(last_cd[0])) begin
      fails++;
      $display("FAIL bad_digit: fed=%0d err=%b busy=%b valid=%b ready=%b cd=%0d expected 5 1 0 0 0 %0d",
               idx, err[0], busy[0], out_valid[0], digit_ready[0], check_digit[0], last_cd[0]);
    end
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      digit_valid[0] = 1'b1;
      digit_in[0]    = 4'($urandom_range(0, 9));
      @(negedge clk);
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) leak = 1'b1;
    end
    digit_valid[0] = 1'b0;
    tests++;
    if (leak || err[0] !== 1'b1) begin
      fails++;
      $display("FAIL bad_digit_idle: leak=%b err=%b expected 0 1", leak, err[0]);
    end
  endtask

  task automatic test_reset_mid_emit();
    run_card(0, str_digits("453914880343646"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    run_card(0, str_digits("453914880343646"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    tests++;
    if (check_digit[0] !== 4'd7) begin
      fails++;
      $display("FAIL after_reset: check_digit %0d expected 7", check_digit[0]);
    end
  endtask

  task automatic test_random();
    dq_t pay;
    bit  b2b;
    bit  pre;
    for (int s = 0; s < 2; s++) begin
      pre = 1'b0;
      for (int n = 0; n < 12; n++) begin
        pay.delete();
        for (int i = 0; i < card_len(s) - 1; i++) pay.push_back($urandom_range(0, 9));
        b2b = (n == 11) ? 1'b0 : 1'($urandom_range(0, 1));
        run_card(s, pay, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), b2b, pre, -1);
        pre = b2b;
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_16();
    test_back_to_back();
    test_len11();
    test_stall();
    test_bad_digit();
    test_reset_mid_emit();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
